// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Define DCACHE_STATS_EN to add the hit_count/miss_count load counters.
module dcache_ctrl #(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int OW = $clog2(WORDS_PER_LINE);
   localparam int IW = $clog2(LINES);
   localparam int TW = 30 - OW - IW;
   localparam int AW = OW + IW;
   localparam logic [31:0] LINE_MASK =
      32'(WORDS_PER_LINE * 4 - 1);

   typedef enum logic [1:0] {
      IDLE, REFILL, WRITE, RESP
   } state_t;

   state_t           state_q, state_d;
   logic [29:0]      lat_q, lat_d;
   logic [OW-1:0]    cnt_q, cnt_d;
   logic [LINES-1:0] valid_q, valid_d;
   logic [TW-1:0]    tag_q [LINES];
   logic [31:0]      data_q [LINES*WORDS_PER_LINE];

   logic        resp_valid_d, mem_req_d, mem_we_d;
   logic [31:0] resp_data_d, mem_addr_d, mem_wdata_d;
   logic        arr_we, tag_we;
   logic [AW-1:0] arr_addr;
   logic [31:0] arr_wdata;

   logic [OW-1:0] req_off, lat_off;
   logic [IW-1:0] req_idx, lat_idx;
   logic [TW-1:0] req_tag, lat_tag;
   logic          hit;

   assign req_off = req_addr[2 +: OW];
   assign req_idx = req_addr[2+OW +: IW];
   assign req_tag = req_addr[31 -: TW];
   assign lat_off = lat_q[0 +: OW];
   assign lat_idx = lat_q[OW +: IW];
   assign lat_tag = lat_q[29 -: TW];
   assign hit = valid_q[req_idx] &&
                (tag_q[req_idx] == req_tag);
   assign req_ready = (state_q == IDLE);

   always_comb begin
      state_d      = state_q;
      lat_d        = lat_q;
      cnt_d        = cnt_q;
      valid_d      = valid_q;
      resp_valid_d = 1'b0;
      resp_data_d  = '0;
      mem_req_d    = mem_req;
      mem_we_d     = mem_we;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      arr_we       = 1'b0;
      arr_addr     = '0;
      arr_wdata    = '0;
      tag_we       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               lat_d = req_addr[31:2];
               if (req_we) begin
                  state_d     = WRITE;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = req_addr & ~32'h3;
                  mem_wdata_d = req_wdata;
                  arr_we      = hit;
                  arr_addr    = {req_idx, req_off};
                  arr_wdata   = req_wdata;
               end else if (hit) begin
                  resp_valid_d = 1'b1;
                  resp_data_d  =
                     data_q[{req_idx, req_off}];
               end else begin
                  state_d          = REFILL;
                  valid_d[req_idx] = 1'b0;
                  mem_req_d        = 1'b1;
                  mem_we_d         = 1'b0;
                  mem_addr_d       = req_addr & ~LINE_MASK;
                  cnt_d            = '0;
               end
            end
         end
         REFILL: begin
            if (mem_ack) begin
               arr_we     = 1'b1;
               arr_addr   = {lat_idx, cnt_q};
               arr_wdata  = mem_rdata;
               mem_addr_d = mem_addr + 32'd4;
               cnt_d      = cnt_q + OW'(1);
               if (&cnt_q) begin
                  // requested word may be the one arriving now
                  state_d          = RESP;
                  mem_req_d        = 1'b0;
                  tag_we           = 1'b1;
                  valid_d[lat_idx] = 1'b1;
                  resp_valid_d     = 1'b1;
                  resp_data_d = (lat_off == cnt_q) ?
                     mem_rdata :
                     data_q[{lat_idx, lat_off}];
               end
            end
         end
         WRITE: begin
            if (mem_ack) begin
               state_d      = RESP;
               mem_req_d    = 1'b0;
               mem_we_d     = 1'b0;
               resp_valid_d = 1'b1;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         lat_q      <= '0;
         cnt_q      <= '0;
         valid_q    <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state_q    <= state_d;
         lat_q      <= lat_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         resp_valid <= resp_valid_d;
         resp_data  <= resp_data_d;
         mem_req    <= mem_req_d;
         mem_we     <= mem_we_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
      end
   end

   // storage arrays carry no reset; valid bits gate them
   always_ff @(posedge clock) begin
      if (arr_we)
         data_q[arr_addr] <= arr_wdata;
      if (tag_we)
         tag_q[lat_idx] <= lat_tag;
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (req_valid && req_ready && !req_we) begin
         if (hit)
            hit_count <= hit_count + 32'd1;
         else
            miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: cache/memory model, memory responder,
// per-cycle response and memory-traffic checks plus directed tests.
module tb_dcache_ctrl;

   localparam int LINES = 16;
   localparam int WPL   = 4;
   localparam int LB    = 4 * WPL;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid, req_we;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, resp_valid;
   logic [31:0] resp_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   always #5 clock = ~clock;

   dcache_ctrl #(
      .LINES(LINES),
      .WORDS_PER_LINE(WPL)
   ) dut (
      .clock(clock),
      .reset(reset),
      .req_valid(req_valid),
      .req_we(req_we),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .req_ready(req_ready),
      .resp_valid(resp_valid),
      .resp_data(resp_data),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ack(mem_ack),
      .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count(hit_count),
      .miss_count(miss_count)
`endif
   );

   typedef struct {
      logic [31:0] data;
      int          acc;
      bit          hit;
   } resp_t;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
   } mop_t;

   resp_t exp_resp[$];
   mop_t  exp_mem[$];
   logic [31:0] bm [logic [31:0]];
   bit          mvalid [LINES];
   int unsigned mtag [LINES];
   logic [31:0] mdata [LINES][WPL];
   logic [31:0] rd_log[$], wr_log[$], resp_log[$];

   int compared = 0, mismatched = 0;
   int cyc = 0, last_ack_cyc = 0, ack_delay = 2;
   int n_rd = 0, n_wr = 0;
   int unsigned mhits = 0, mmisses = 0;

   function automatic logic [31:0] mem_word(
      input logic [31:0] a);
      if (bm.exists(a))
         return bm[a];
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h want %h",
                  name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s", name);
   endtask

   task automatic model_accept(input bit we,
                               input logic [31:0] a,
                               input logic [31:0] d);
      int unsigned ua  = a;
      int          off = int'((ua / 4) % WPL);
      int          idx = int'((ua / LB) % LINES);
      int unsigned tag = ua / (LB * LINES);
      int unsigned base = ua - (ua % LB);
      bit          h = mvalid[idx] && (mtag[idx] == tag);
      resp_t r;
      mop_t  m;
      r.acc  = cyc;
      r.hit  = 1'b0;
      r.data = '0;
      if (we) begin
         m.we = 1'b1;
         m.addr = a & ~32'h3;
         m.data = d;
         exp_mem.push_back(m);
         if (h) mdata[idx][off] = d;
      end else if (h) begin
         r.hit  = 1'b1;
         r.data = mdata[idx][off];
         mhits++;
      end else begin
         for (int i = 0; i < WPL; i++) begin
            m.we = 1'b0;
            m.addr = base + 32'(4 * i);
            m.data = '0;
            exp_mem.push_back(m);
            mdata[idx][i] = mem_word(m.addr);
         end
         mvalid[idx] = 1'b1;
         mtag[idx] = tag;
         r.data = mdata[idx][off];
         mmisses++;
      end
      exp_resp.push_back(r);
   endtask

   task automatic flush_model();
      exp_mem.delete();
      exp_resp.delete();
      for (int i = 0; i < LINES; i++)
         mvalid[i] = 1'b0;
      mhits = 0;
      mmisses = 0;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      req_we = 1'b0;
      req_addr = '0;
      req_wdata = '0;
   endtask

   // called just after a falling edge; returns one cycle later
   task automatic issue(input bit we,
                        input logic [31:0] a,
                        input logic [31:0] d);
      int n = 0;
      req_valid = 1'b1;
      req_we = we;
      req_addr = a;
      req_wdata = d;
      while (!req_ready) begin
         if (n >= 500) begin
            fail_now("issue_timeout");
            idle();
            return;
         end
         @(negedge clock);
         n++;
      end
      model_accept(we, a, d);
      @(negedge clock);
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (exp_resp.size() != 0 && n < 400) begin
         @(negedge clock);
         n++;
      end
      if (exp_resp.size() != 0)
         fail_now({nm, "_resp_timeout"});
      @(negedge clock);
   endtask

   initial begin : responder
      int wait_n = 0;
      mop_t m;
      forever begin
         @(negedge clock);
         mem_ack = 1'b0;
         if (!reset || !mem_req) begin
            wait_n = 0;
         end else if (wait_n < ack_delay) begin
            wait_n++;
         end else begin
            wait_n = 0;
            mem_ack = 1'b1;
            last_ack_cyc = cyc;
            if (exp_mem.size() == 0) begin
               fail_now("mem_unexpected");
            end else begin
               m = exp_mem.pop_front();
               chk("mem_we", 32'(mem_we), 32'(m.we));
               chk("mem_addr", mem_addr, m.addr);
               if (m.we)
                  chk("mem_wdata", mem_wdata, m.data);
            end
            if (mem_we) begin
               bm[mem_addr] = mem_wdata;
               n_wr++;
               wr_log.push_back(mem_addr);
            end else begin
               mem_rdata = mem_word(mem_addr);
               n_rd++;
               rd_log.push_back(mem_addr);
            end
         end
      end
   end

   initial begin : compare
      resp_t r;
      int due;
      forever begin
         @(posedge clock);
         cyc++;
         #1;
         if (reset) begin
            if (exp_mem.size() == 0)
               chk("mem_idle", 32'(mem_req), 32'd0);
            if (resp_valid) begin
               if (exp_resp.size() == 0) begin
                  fail_now("resp_unexpected");
               end else begin
                  r = exp_resp.pop_front();
                  due = r.hit ? r.acc + 1
                              : last_ack_cyc + 1;
                  chk("resp_data", resp_data, r.data);
                  chk("resp_time", 32'(cyc), 32'(due));
                  resp_log.push_back(resp_data);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1, "timeout");
   end

   initial begin : main
      int brd, bwr, n;
      idle();
      for (int i = 0; i < WPL; i++)
         bm[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
      flush_model();
      repeat (2) @(negedge clock);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
`ifdef DCACHE_STATS_EN
      chk("rst_hits", hit_count, 32'd0);
      chk("rst_misses", miss_count, 32'd0);
`endif
      reset = 1'b1;
      @(negedge clock);

      // cold load miss, slow memory
      ack_delay = 2;
      brd = n_rd;
      issue(1'b0, 32'h100, '0);
      idle();
      drain("t1");
      chk("t1_reads", 32'(n_rd - brd), 32'd4);
      chk("t1_addr0", rd_log[0], 32'h100);
      chk("t1_addr3", rd_log[3], 32'h10C);
      chk("t1_resp", resp_log[$], 32'hA0);

      // back-to-back hits
      brd = n_rd;
      issue(1'b0, 32'h104, '0);
      issue(1'b0, 32'h10C, '0);
      idle();
      drain("t2");
      chk("t2_reads", 32'(n_rd - brd), 32'd0);
      chk("t2_resp0", resp_log[$-1], 32'hA1);
      chk("t2_resp1", resp_log[$], 32'hA3);

      // store hit then load of same word
      bwr = n_wr;
      issue(1'b1, 32'h108, 32'hDEAD_BEEF);
      idle();
      drain("t3s");
      chk("t3_writes", 32'(n_wr - bwr), 32'd1);
      chk("t3_waddr", wr_log[$], 32'h108);
      chk("t3_sresp", resp_log[$], 32'd0);
      brd = n_rd;
      issue(1'b0, 32'h108, '0);
      idle();
      drain("t3l");
      chk("t3_lresp", resp_log[$], 32'hDEAD_BEEF);
      chk("t3_reads", 32'(n_rd - brd), 32'd0);

      // store miss: no allocation
      ack_delay = 1;
      issue(1'b1, 32'h2040, 32'h1234_5678);
      idle();
      drain("t4s");
      brd = n_rd;
      issue(1'b0, 32'h2040, '0);
      idle();
      drain("t4l");
      chk("t4_reads", 32'(n_rd - brd), 32'd4);
      chk("t4_resp", resp_log[$], 32'h1234_5678);

      // conflict miss on index 0, zero-latency acks
      ack_delay = 0;
      brd = n_rd;
      issue(1'b0, 32'h100, '0);
      idle();
      drain("t5a");
      chk("t5_hit_reads", 32'(n_rd - brd), 32'd0);
      issue(1'b0, 32'h100 + 32'(LINES * LB), '0);
      idle();
      drain("t5b");
      chk("t5_conf_resp", resp_log[$], 32'h5A5A_0200);
      issue(1'b0, 32'h100, '0);
      idle();
      drain("t5c");
      chk("t5_reads", 32'(n_rd - brd), 32'd8);
      chk("t5_resp", resp_log[$], 32'hA0);
`ifdef DCACHE_STATS_EN
      chk("t5_hits", hit_count, 32'(mhits));
      chk("t5_misses", miss_count, 32'(mmisses));
`endif

      // reset in the middle of a refill
      ack_delay = 2;
      brd = n_rd;
      issue(1'b0, 32'h300, '0);
      idle();
      n = 0;
      while (n_rd - brd < 2 && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("t6_pre_acks", 32'(n_rd - brd), 32'd2);
      @(posedge clock);
      #2;
      reset = 1'b0;
      flush_model();
      #1;
      chk("t6_req_drop", 32'(mem_req), 32'd0);
      chk("t6_resp_valid", 32'(resp_valid), 32'd0);
      chk("t6_mem_addr", mem_addr, 32'd0);
`ifdef DCACHE_STATS_EN
      chk("t6_hits0", hit_count, 32'd0);
      chk("t6_misses0", miss_count, 32'd0);
`endif
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      brd = n_rd;
      issue(1'b0, 32'h300, '0);
      idle();
      drain("t6");
      chk("t6_reads", 32'(n_rd - brd), 32'd4);
      chk("t6_addr0", rd_log[$-3], 32'h300);
      chk("t6_resp", resp_log[$], 32'h5A5A_0300);
`ifdef DCACHE_STATS_EN
      chk("t6_hits", hit_count, 32'd0);
      chk("t6_misses", miss_count, 32'd1);
`endif
      repeat (3) @(negedge clock);
      chk("end_mem_q", 32'(exp_mem.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
